// File: rtl/puf_sequencer_pkg.sv
// rtl/puf_sequencer_pkg.sv - shared types and widths for the PUF challenge sequencer
// Purpose: state enumeration plus count and select width constants.
// Ports: none (package).
package puf_sequencer_pkg;

  localparam int CNT_W = 16;  // oscillator count width and cycle counter width
  localparam int SEL_W = 4;   // ring-oscillator mux select width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_MEASURE,
    ST_WAIT,
    ST_DECIDE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/puf_sequencer_cmp.sv
// rtl/puf_sequencer_cmp.sv - 16-bit unsigned greater-than comparator
// Purpose: gt_o = (a_i > b_i), unsigned.
// Ports: a_i, b_i (CNT_W bits) operands; gt_o result.
module puf_sequencer_cmp
  import puf_sequencer_pkg::*;
(
  input  logic [CNT_W-1:0] a_i,
  input  logic [CNT_W-1:0] b_i,
  output logic             gt_o
);

  assign gt_o = (a_i > b_i);

endmodule

// File: rtl/puf_sequencer.sv
// rtl/puf_sequencer.sv - ring-oscillator PUF challenge/response sequencer
// Purpose: for each challenge byte, select an oscillator pair, clear counters,
//   settle, measure for a window, wait for counts to sync, then decide one bit.
// Ports: clk, rst (async, active-high); start, abort control; challenge
//   (byte i = {sel_a, sel_b} for bit i); count_1/count_2 oscillator counts;
//   ro_sel_a/ro_sel_b, ro_en, cnt_clr oscillator controls; busy, done status;
//   response, tie, err result vectors.
module puf_sequencer
  import puf_sequencer_pkg::*;
#(
  parameter int N_BITS = 8,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  parameter int SYNC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8*N_BITS-1:0]   challenge,
  input  logic [CNT_W-1:0]      count_1,
  input  logic [CNT_W-1:0]      count_2,
  output logic [SEL_W-1:0]      ro_sel_a,
  output logic [SEL_W-1:0]      ro_sel_b,
  output logic                  ro_en,
  output logic                  cnt_clr,
  output logic                  busy,
  output logic                  done,
  output logic [N_BITS-1:0]     response,
  output logic [N_BITS-1:0]     tie,
  output logic [N_BITS-1:0]     err
);

  localparam int                IDX_W     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_BITS - 1);
  // Counter holds "cycles remaining minus one" in the current state.
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  WINDOW_LD = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  SYNC_LD   = CNT_W'(SYNC - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [8*N_BITS-1:0]   chal_q, chal_d;
  logic [N_BITS-1:0]     sh_resp_q, sh_resp_d;
  logic [N_BITS-1:0]     sh_tie_q, sh_tie_d;
  logic [N_BITS-1:0]     sh_err_q, sh_err_d;
  logic [N_BITS-1:0]     resp_q, resp_d;
  logic [N_BITS-1:0]     tie_q, tie_d;
  logic [N_BITS-1:0]     err_q, err_d;

  logic [7:0]            cur_byte;
  logic                  pair_ok;
  logic                  cnt_eq;
  logic                  cnt_gt;

  assign cur_byte = chal_q[{idx_q, 3'b000} +: 8];
  assign pair_ok  = (cur_byte[7:4] != cur_byte[3:0]);
  assign cnt_eq   = (count_1 == count_2);

  puf_sequencer_cmp u_cmp (
    .a_i  (count_1),
    .b_i  (count_2),
    .gt_o (cnt_gt)
  );

  // Selects follow the latched byte for the bit in flight and park at 0 in IDLE.
  assign ro_sel_a = (state_q == ST_IDLE) ? '0 : cur_byte[7:4];
  assign ro_sel_b = (state_q == ST_IDLE) ? '0 : cur_byte[3:0];
  assign busy     = (state_q != ST_IDLE);
  assign response = resp_q;
  assign tie      = tie_q;
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    chal_d    = chal_q;
    sh_resp_d = sh_resp_q;
    sh_tie_d  = sh_tie_q;
    sh_err_d  = sh_err_q;
    resp_d    = resp_q;
    tie_d     = tie_q;
    err_d     = err_q;
    ro_en     = 1'b0;
    cnt_clr   = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          chal_d  = challenge;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        cnt_clr = 1'b1;
        cnt_d   = SETTLE_LD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cnt_d   = WINDOW_LD;
          state_d = ST_MEASURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_MEASURE: begin
        ro_en = 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = SYNC_LD;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DECIDE: begin
        if (pair_ok) begin
          sh_resp_d[idx_q] = cnt_gt;
          sh_tie_d[idx_q]  = cnt_eq;
          sh_err_d[idx_q]  = 1'b0;
        end else begin
          sh_resp_d[idx_q] = 1'b0;
          sh_tie_d[idx_q]  = 1'b0;
          sh_err_d[idx_q]  = 1'b1;
        end
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          // Publish on DONE entry so results are valid in the done cycle.
          resp_d  = sh_resp_d;
          tie_d   = sh_tie_d;
          err_d   = sh_err_d;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything outside IDLE, including the final publish.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ro_en   = 1'b0;
      cnt_clr = 1'b0;
      done    = 1'b0;
      resp_d  = resp_q;
      tie_d   = tie_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      chal_q    <= '0;
      sh_resp_q <= '0;
      sh_tie_q  <= '0;
      sh_err_q  <= '0;
      resp_q    <= '0;
      tie_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      chal_q    <= chal_d;
      sh_resp_q <= sh_resp_d;
      sh_tie_q  <= sh_tie_d;
      sh_err_q  <= sh_err_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_puf_sequencer.sv
// tb/tb_puf_sequencer.sv - self-checking bench for puf_sequencer
module tb_puf_sequencer;

  localparam int NB  = 4;
  localparam int WIN = 16;
  localparam int SET = 2;
  localparam int SYN = 2;
  localparam int PB  = SET + WIN + SYN + 2;  // cycles per bit
  localparam int RUN = NB * PB + 1;          // cycle number of the done pulse

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] challenge = '0;
  logic [15:0] count_1 = '0;
  logic [15:0] count_2 = '0;
  logic [3:0]  ro_sel_a, ro_sel_b;
  logic        ro_en, cnt_clr, busy, done;
  logic [3:0]  response, tie, err;

  always #5 clk = ~clk;

  puf_sequencer #(.N_BITS(NB), .WINDOW(WIN), .SETTLE(SET), .SYNC(SYN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .challenge (challenge),
    .count_1   (count_1),
    .count_2   (count_2),
    .ro_sel_a  (ro_sel_a),
    .ro_sel_b  (ro_sel_b),
    .ro_en     (ro_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .tie       (tie),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run_n is the cycle number within a run (1 = first cycle
  // after the start edge, RUN = done cycle), 0 when idle.
  int          run_n = 0;
  logic [31:0] m_chal = '0;
  logic [3:0]  m_resp = '0, m_tie = '0, m_err = '0;
  logic [3:0]  exp_resp = '0, exp_tie = '0, exp_err = '0;
  logic [15:0] c1_tab [4];
  logic [15:0] c2_tab [4];

  always @(posedge clk or posedge rst) begin
    int mk;
    logic [7:0] mb;
    if (rst) begin
      run_n = 0;
      m_resp = '0; m_tie = '0; m_err = '0;
      exp_resp = '0; exp_tie = '0; exp_err = '0;
    end else if (run_n == 0) begin
      if (start && !abort) begin
        run_n  = 1;
        m_chal = challenge;
      end
    end else if (abort) begin
      run_n = 0;
    end else if (run_n == RUN) begin
      run_n = 0;
    end else begin
      if ((run_n - 1) % PB == PB - 1) begin
        mk = (run_n - 1) / PB;
        mb = m_chal[8*mk +: 8];
        if (mb[7:4] == mb[3:0]) begin
          m_resp[mk] = 1'b0; m_tie[mk] = 1'b0; m_err[mk] = 1'b1;
        end else begin
          m_resp[mk] = (count_1 > count_2);
          m_tie[mk]  = (count_1 == count_2);
          m_err[mk]  = 1'b0;
        end
      end
      run_n++;
      if (run_n == RUN) begin
        exp_resp = m_resp; exp_tie = m_tie; exp_err = m_err;
      end
    end
  end

  // Counts presented for the bit currently being measured.
  always @(negedge clk) begin
    if (run_n >= 1 && run_n < RUN) begin
      count_1 = c1_tab[(run_n - 1) / PB];
      count_2 = c2_tab[(run_n - 1) / PB];
    end
  end

  int ro_total = 0;

  always @(negedge clk) begin
    int k, off;
    logic [7:0] b;
    logic e_clr, e_en, e_done, e_sel_chk;
    logic [3:0] e_sa, e_sb;
    e_clr = 1'b0; e_en = 1'b0; e_done = 1'b0; e_sel_chk = 1'b1;
    e_sa = '0; e_sb = '0;
    if (run_n >= 1 && run_n < RUN) begin
      k     = (run_n - 1) / PB;
      off   = (run_n - 1) % PB;
      b     = m_chal[8*k +: 8];
      e_sa  = b[7:4];
      e_sb  = b[3:0];
      e_clr = (off == 0) && !abort;
      e_en  = (off >= 1 + SET) && (off < 1 + SET + WIN) && !abort;
    end else if (run_n == RUN) begin
      e_done    = !abort;
      e_sel_chk = 1'b0;
    end
    chk("busy", busy, run_n != 0);
    chk("cnt_clr", cnt_clr, e_clr);
    chk("ro_en", ro_en, e_en);
    chk("done", done, e_done);
    chk("response", response, exp_resp);
    chk("tie", tie, exp_tie);
    chk("err", err, exp_err);
    chk("en_clr_excl", ro_en & cnt_clr, 0);
    if (e_sel_chk) begin
      chk("ro_sel_a", ro_sel_a, e_sa);
      chk("ro_sel_b", ro_sel_b, e_sb);
    end
    if (ro_en) ro_total++;
  end

  task automatic set_counts(input logic [15:0] a0, a1, a2, a3, input logic [15:0] b);
    c1_tab[0] = a0; c1_tab[1] = a1; c1_tab[2] = a2; c1_tab[3] = a3;
    for (int i = 0; i < 4; i++) c2_tab[i] = b;
  endtask

  // Returns just after the start-sampling edge; challenge is then scrambled.
  task automatic start_run(input logic [31:0] ch);
    @(posedge clk); #1;
    challenge = ch; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; challenge = ~ch;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 300);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    int lat, ro0;
    set_counts(16'd100, 16'd100, 16'd100, 16'd100, 16'd50);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_response", response, 0);
    chk("rst_sel", {ro_sel_a, ro_sel_b}, 0);
    rst = 1'b0;

    // All bits A faster than B.
    ro0 = ro_total;
    start_run(32'h32102301);
    wait_done(lat);
    chk("t1_latency", lat, 89);
    chk("t1_response", response, 4'hF);
    chk("t1_tie", tie, 4'h0);
    chk("t1_err", err, 4'h0);
    chk("t1_ro_en_cycles", ro_total - ro0, 64);

    // Tie on bit 1.
    set_counts(16'd100, 16'd50, 16'd100, 16'd100, 16'd50);
    start_run(32'h32102301);
    wait_done(lat);
    chk("t2_response", response, 4'hD);
    chk("t2_tie", tie, 4'h2);

    // Illegal pair in byte 2.
    set_counts(16'd100, 16'd100, 16'd100, 16'd100, 16'd50);
    start_run(32'h32552301);
    wait_done(lat);
    chk("t3_err", err, 4'h4);
    chk("t3_response", response, 4'hB);
    chk("t3_tie", tie, 4'h0);

    // Abort in MEASURE of bit 2, restart immediately.
    set_counts(16'd10, 16'd10, 16'd10, 16'd200, 16'd50);
    start_run(32'h32102301);
    repeat (54) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_idle_after_abort", busy, 0);
    chk("t4_response_kept", response, 4'hB);
    challenge = 32'h32102301; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_restart_busy", busy, 1);
    wait_done(lat);
    chk("t4_latency", lat, 89);
    chk("t4_response", response, 4'h8);
    chk("t4_err", err, 4'h0);

    // start together with abort in IDLE is refused.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t4_abort_wins", busy, 0);

    // Reset in WAIT of bit 1, with a start pulse while busy.
    set_counts(16'd100, 16'd100, 16'd100, 16'd100, 16'd50);
    start_run(32'h10322301);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (31) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ctrl", {done, ro_en, cnt_clr}, 0);
    chk("t5_rst_sel", {ro_sel_a, ro_sel_b}, 0);
    chk("t5_rst_results", {response, tie, err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start_run(32'h10322301);
    wait_done(lat);
    chk("t5_latency", lat, 89);
    chk("t5_response", response, 4'hF);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
